pcie_legacyint_receiver: RTL and testbench

Root-port side counterpart of the endpoint legacy INTx next-state logic. It accepts decoded Assert_INTx/Deassert_INTx messages, tracks one virtual-wire state machine per INTA..INTD, and offers pending interrupts to the host interrupt controller over a valid/ready handshake. It also counts protocol violations and sits between the message decoder and the host interrupt fabric.

---
 rtl/pcie_legacyint_pkg.sv | 30 +++
 rtl/pcie_legacyint_line_fsm.sv | 52 +++++
 rtl/pcie_legacyint_receiver.sv | 175 +++++++++++++++++
 tb/tb_pcie_legacyint_receiver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_legacyint_pkg.sv
// pcie_legacyint_pkg
// Shared definitions for the root-port legacy INTx receiver: the per-line
// virtual-wire state encoding, the Assert/Deassert_INTx message codes and the
// number of INTx lines.
package pcie_legacyint_pkg;

  localparam int NUM_INTX = 4;

  typedef enum logic [1:0] {
    LINE_IDLE      = 2'd0,
    LINE_PENDING   = 2'd1,
    LINE_SERVICING = 2'd2
  } line_state_e;

  localparam logic [7:0] ASSERT_INTA   = 8'h20;
  localparam logic [7:0] ASSERT_INTB   = 8'h21;
  localparam logic [7:0] ASSERT_INTC   = 8'h22;
  localparam logic [7:0] ASSERT_INTD   = 8'h23;
  localparam logic [7:0] DEASSERT_INTA = 8'h24;
  localparam logic [7:0] DEASSERT_INTB = 8'h25;
  localparam logic [7:0] DEASSERT_INTC = 8'h26;
  localparam logic [7:0] DEASSERT_INTD = 8'h27;

  // All eight INTx codes share the upper five bits; bit 2 selects deassert,
  // bits 1:0 select the line.
  function automatic logic is_intx_code(input logic [7:0] code);
    return code[7:3] == ASSERT_INTA[7:3];
  endfunction

endpackage

// File: rtl/pcie_legacyint_line_fsm.sv
// pcie_legacyint_line_fsm
// Virtual-wire state machine for one INTx line.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   intx_assert    : Assert_INTx for this line is being applied
//   intx_deassert  : Deassert_INTx for this line is being applied
//   grant          : host accepted the offer of this line
//   state          : current line state
//   err            : Deassert seen while IDLE (single-cycle pulse)
module pcie_legacyint_line_fsm
  import pcie_legacyint_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        intx_assert,
  input  logic        intx_deassert,
  input  logic        grant,
  output line_state_e state,
  output logic        err
);

  line_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= LINE_IDLE;
    else       state_q <= state_d;
  end

  // A deassert wins over a same-edge grant: the accept still happens on the
  // handshake, but the line ends up IDLE.
  always_comb begin
    state_d = state_q;
    err     = 1'b0;
    case (state_q)
      LINE_IDLE: begin
        if (intx_deassert)    err     = 1'b1;
        else if (intx_assert) state_d = LINE_PENDING;
      end
      LINE_PENDING: begin
        if (intx_deassert) state_d = LINE_IDLE;
        else if (grant)    state_d = LINE_SERVICING;
      end
      LINE_SERVICING: begin
        if (intx_deassert) state_d = LINE_IDLE;
      end
      default: state_d = LINE_IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/pcie_legacyint_receiver.sv
// pcie_legacyint_receiver
// Root-port receiver for legacy INTx messages. Decoded Assert/Deassert_INTx
// messages pass through a one-entry message register into four line FSMs;
// pending lines are offered to the host one at a time by a round-robin
// arbiter over a valid/ready handshake. Unexpected messages are counted.
// Optional feature macro: PCIE_INTX_SWIZZLE_EN (bridge swizzle of the target
// line by requester device number).
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   msg_valid_i    : message present
//   msg_ready_o    : message register free
//   msg_code_i     : message code (0x20..0x27 are INTx messages)
//   msg_dev_i      : requester device number (swizzle only)
//   irq_valid_o    : pending interrupt offered to host
//   irq_line_o     : offered line (0=A..3=D)
//   irq_ready_i    : host accepts offer
//   line_level_o   : per-line level, 1 while PENDING or SERVICING
//   err_cnt_o      : saturating count of unexpected messages
module pcie_legacyint_receiver
  import pcie_legacyint_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 msg_valid_i,
  output logic                 msg_ready_o,
  input  logic [7:0]           msg_code_i,
  input  logic [4:0]           msg_dev_i,
  output logic                 irq_valid_o,
  output logic [1:0]           irq_line_o,
  input  logic                 irq_ready_i,
  output logic [3:0]           line_level_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  // First candidate found scanning base+1, base+2, ... wrapping; {found, line}.
  function automatic logic [2:0] rr_pick(input logic [NUM_INTX-1:0] cand,
                                         input logic [1:0]          base);
    logic [2:0] r;
    logic [1:0] idx;
    r = '0;
    for (int i = 1; i <= NUM_INTX; i++) begin
      idx = base + 2'(i);
      if (!r[2] && cand[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  logic                reg_full;
  logic [7:0]          code_p0;
  logic [1:0]          line_sel;
  logic                code_ok;
  logic                bad_code;
  logic [NUM_INTX-1:0] assert_v;
  logic [NUM_INTX-1:0] deassert_v;
  logic [NUM_INTX-1:0] grant_v;
  logic [NUM_INTX-1:0] line_err;
  logic [NUM_INTX-1:0] cand;
  line_state_e         line_state [NUM_INTX];
  logic                accepted;
  logic                withdraw;
  logic [1:0]          rr_ptr;
  logic [1:0]          rr_base;
  logic [2:0]          pick;
  logic                err_inc;

  // ---- stage p0: one-entry message register ----
  assign msg_ready_o = !reg_full;

  always_ff @(posedge clk) begin
    if (reset)                  reg_full <= 1'b0;
    else if (reg_full)          reg_full <= 1'b0;
    else if (msg_valid_i)       reg_full <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (msg_valid_i && msg_ready_o) code_p0 <= msg_code_i;
  end

`ifdef PCIE_INTX_SWIZZLE_EN
  logic [1:0] dev_p0;
  logic [2:0] unused_dev;
  assign unused_dev = msg_dev_i[4:2];

  always_ff @(posedge clk) begin
    if (msg_valid_i && msg_ready_o) dev_p0 <= msg_dev_i[1:0];
  end

  assign line_sel = code_p0[1:0] + dev_p0;
`else
  logic [4:0] unused_dev;
  assign unused_dev = msg_dev_i;
  assign line_sel   = code_p0[1:0];
`endif

  // ---- stage p1: decode and apply to line FSMs ----
  always_comb begin
    code_ok    = reg_full && is_intx_code(code_p0);
    bad_code   = reg_full && !code_ok;
    assert_v   = '0;
    deassert_v = '0;
    if (code_ok) begin
      if (code_p0[2]) deassert_v[line_sel] = 1'b1;
      else            assert_v[line_sel]   = 1'b1;
    end
  end

  assign accepted = irq_valid_o && irq_ready_i;

  always_comb begin
    grant_v = '0;
    if (accepted) grant_v[irq_line_o] = 1'b1;
  end

  for (genvar g = 0; g < NUM_INTX; g++) begin : g_line
    pcie_legacyint_line_fsm u_fsm (
      .clk           (clk),
      .reset         (reset),
      .intx_assert   (assert_v[g]),
      .intx_deassert (deassert_v[g]),
      .grant         (grant_v[g]),
      .state         (line_state[g]),
      .err           (line_err[g])
    );
  end

  always_comb begin
    line_level_o = '0;
    for (int i = 0; i < NUM_INTX; i++) begin
      line_level_o[i] = (line_state[i] == LINE_PENDING) ||
                        (line_state[i] == LINE_SERVICING);
    end
  end

  // ---- stage p2: registered round-robin offer ----
  // Lines being withdrawn on this edge are never loaded, so a freshly loaded
  // offer always refers to a line that is still PENDING after the edge.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_INTX; i++) begin
      cand[i] = (line_state[i] == LINE_PENDING) && !deassert_v[i];
    end
    if (accepted) cand[irq_line_o] = 1'b0;
  end

  assign rr_base  = accepted ? irq_line_o : rr_ptr;
  assign pick     = rr_pick(cand, rr_base);
  assign withdraw = irq_valid_o && !irq_ready_i && deassert_v[irq_line_o];

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_valid_o <= 1'b0;
      irq_line_o  <= '0;
      rr_ptr      <= '0;
    end else begin
      if (accepted) rr_ptr <= irq_line_o;
      if (!irq_valid_o || irq_ready_i) begin
        irq_valid_o <= pick[2];
        if (pick[2]) irq_line_o <= pick[1:0];
      end else if (withdraw) begin
        irq_valid_o <= 1'b0;
      end
    end
  end

  // At most one message is applied per edge, so at most one increment.
  assign err_inc = bad_code || (|line_err);

  always_ff @(posedge clk) begin
    if (reset)                         err_cnt_o <= '0;
    else if (err_inc && !(&err_cnt_o)) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
  end

endmodule

// File: tb/tb_pcie_legacyint_receiver.sv
module tb_pcie_legacyint_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       msg_valid_i;
  logic [7:0] msg_code_i;
  logic [4:0] msg_dev_i;
  logic       irq_ready_i;

  logic       msg_ready_o;
  logic       irq_valid_o;
  logic [1:0] irq_line_o;
  logic [3:0] line_level_o;
  logic [7:0] err_cnt_o;

  logic       msg_ready_s;
  logic       irq_valid_s;
  logic [1:0] irq_line_s;
  logic [3:0] line_level_s;
  logic [1:0] err_cnt_s;

`ifdef PCIE_INTX_SWIZZLE_EN
  localparam logic [1:0] SWZ_LINE = 2'd3;
`else
  localparam logic [1:0] SWZ_LINE = 2'd0;
`endif

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int hs_before;
  logic [3:0] swz_level;

  pcie_legacyint_receiver #(.ERR_CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .msg_valid_i  (msg_valid_i),
    .msg_ready_o  (msg_ready_o),
    .msg_code_i   (msg_code_i),
    .msg_dev_i    (msg_dev_i),
    .irq_valid_o  (irq_valid_o),
    .irq_line_o   (irq_line_o),
    .irq_ready_i  (irq_ready_i),
    .line_level_o (line_level_o),
    .err_cnt_o    (err_cnt_o)
  );

  // Narrow-counter instance sharing all stimulus, used for saturation.
  pcie_legacyint_receiver #(.ERR_CNT_W(2)) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .msg_valid_i  (msg_valid_i),
    .msg_ready_o  (msg_ready_s),
    .msg_code_i   (msg_code_i),
    .msg_dev_i    (msg_dev_i),
    .irq_valid_o  (irq_valid_s),
    .irq_line_o   (irq_line_s),
    .irq_ready_i  (irq_ready_i),
    .line_level_o (line_level_s),
    .err_cnt_o    (err_cnt_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && irq_valid_o && irq_ready_i) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for a free register, presents one message for one cycle.
  task automatic send(input logic [7:0] code, input logic [4:0] dev);
    int n = 0;
    while (!msg_ready_o && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", {31'd0, msg_ready_o}, 32'd1);
    msg_valid_i = 1'b1;
    msg_code_i  = code;
    msg_dev_i   = dev;
    @(negedge clk);
    msg_valid_i = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    msg_valid_i = 1'b0;
    msg_code_i  = 8'h00;
    msg_dev_i   = 5'd0;
    irq_ready_i = 1'b0;
    swz_level   = 4'd1 << SWZ_LINE;
    tick(3);
    reset = 1'b0;
    tick(1);

    // reset values
    chk("rst_msg_ready", {31'd0, msg_ready_o}, 32'd1);
    chk("rst_irq_valid", {31'd0, irq_valid_o}, 32'd0);
    chk("rst_irq_line", {30'd0, irq_line_o}, 32'd0);
    chk("rst_level", {28'd0, line_level_o}, 32'd0);
    chk("rst_err", {24'd0, err_cnt_o}, 32'd0);
    chk("rst_err_sat", {30'd0, err_cnt_s}, 32'd0);

    // Assert_INTB with host ready, then Deassert_INTB
    irq_ready_i = 1'b1;
    send(8'h21, 5'd0);
    chk("t1_ready_busy", {31'd0, msg_ready_o}, 32'd0);
    chk("t1_level_early", {28'd0, line_level_o}, 32'd0);
    tick(1);
    chk("t1_level", {28'd0, line_level_o}, 32'b0010);
    tick(1);
    chk("t1_offer_valid", {31'd0, irq_valid_o}, 32'd1);
    chk("t1_offer_line", {30'd0, irq_line_o}, 32'd1);
    tick(1);
    chk("t1_after_accept_valid", {31'd0, irq_valid_o}, 32'd0);
    chk("t1_servicing_level", {28'd0, line_level_o}, 32'b0010);
    chk("t1_handshakes", hs_cnt, 32'd1);
    send(8'h25, 5'd0);
    tick(1);
    chk("t1_deassert_level", {28'd0, line_level_o}, 32'd0);
    chk("t1_err", {24'd0, err_cnt_o}, 32'd0);

    // A, C, D back-to-back with host stalled, then round-robin drain
    irq_ready_i = 1'b0;
    hs_before = hs_cnt;
    send(8'h20, 5'd0);
    send(8'h22, 5'd0);
    send(8'h23, 5'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_valid", {31'd0, irq_valid_o}, 32'd1);
      chk("t2_stall_line", {30'd0, irq_line_o}, 32'd0);
      tick(1);
    end
    chk("t2_level_pending", {28'd0, line_level_o}, 32'b1101);
    irq_ready_i = 1'b1;
    tick(1);
    chk("t2_second_valid", {31'd0, irq_valid_o}, 32'd1);
    chk("t2_second_line", {30'd0, irq_line_o}, 32'd2);
    tick(1);
    chk("t2_third_valid", {31'd0, irq_valid_o}, 32'd1);
    chk("t2_third_line", {30'd0, irq_line_o}, 32'd3);
    tick(1);
    chk("t2_drained", {31'd0, irq_valid_o}, 32'd0);
    chk("t2_level_servicing", {28'd0, line_level_o}, 32'b1101);
    chk("t2_handshakes", hs_cnt - hs_before, 32'd3);
    send(8'h24, 5'd0);
    send(8'h26, 5'd0);
    send(8'h27, 5'd0);
    tick(1);
    chk("t2_cleanup_level", {28'd0, line_level_o}, 32'd0);
    chk("t2_err", {24'd0, err_cnt_o}, 32'd0);

    // withdrawal of an unaccepted offer
    irq_ready_i = 1'b0;
    send(8'h20, 5'd0);
    tick(2);
    chk("t3_offer_valid", {31'd0, irq_valid_o}, 32'd1);
    chk("t3_offer_line", {30'd0, irq_line_o}, 32'd0);
    send(8'h24, 5'd0);
    chk("t3_still_offered", {31'd0, irq_valid_o}, 32'd1);
    tick(1);
    chk("t3_withdrawn_valid", {31'd0, irq_valid_o}, 32'd0);
    chk("t3_withdrawn_level", {28'd0, line_level_o}, 32'd0);
    chk("t3_err", {24'd0, err_cnt_o}, 32'd0);
    tick(1);
    chk("t3_no_reoffer", {31'd0, irq_valid_o}, 32'd0);

    // protocol errors and saturation of the 2-bit counter
    send(8'h26, 5'd0);
    send(8'h30, 5'd0);
    tick(1);
    chk("t4_err2", {24'd0, err_cnt_o}, 32'd2);
    chk("t4_err2_sat", {30'd0, err_cnt_s}, 32'd2);
    chk("t4_level", {28'd0, line_level_o}, 32'd0);
    send(8'hFF, 5'd0);
    tick(1);
    chk("t4_sat_reach", {30'd0, err_cnt_s}, 32'd3);
    send(8'h00, 5'd0);
    send(8'h1F, 5'd0);
    send(8'h28, 5'd0);
    send(8'h24, 5'd0);
    tick(1);
    chk("t4_err7", {24'd0, err_cnt_o}, 32'd7);
    chk("t4_sat_hold", {30'd0, err_cnt_s}, 32'd3);

    // accept and deassert of line D on the same edge
    irq_ready_i = 1'b0;
    send(8'h23, 5'd0);
    tick(2);
    chk("t5_offer_line", {30'd0, irq_line_o}, 32'd3);
    hs_before = hs_cnt;
    send(8'h27, 5'd0);
    chk("t5_offer_held", {31'd0, irq_valid_o}, 32'd1);
    irq_ready_i = 1'b1;
    tick(1);
    chk("t5_valid", {31'd0, irq_valid_o}, 32'd0);
    chk("t5_level", {28'd0, line_level_o}, 32'd0);
    chk("t5_err", {24'd0, err_cnt_o}, 32'd7);
    chk("t5_one_handshake", hs_cnt - hs_before, 32'd1);
    irq_ready_i = 1'b0;

    // reset mid-offer with a message in the register
    send(8'h20, 5'd0);
    tick(2);
    chk("t5r_offer", {31'd0, irq_valid_o}, 32'd1);
    msg_valid_i = 1'b1;
    msg_code_i  = 8'h21;
    tick(1);
    chk("t5r_reg_full", {31'd0, msg_ready_o}, 32'd0);
    msg_valid_i = 1'b0;
    reset = 1'b1;
    tick(1);
    chk("t5r_msg_ready", {31'd0, msg_ready_o}, 32'd1);
    chk("t5r_irq_valid", {31'd0, irq_valid_o}, 32'd0);
    chk("t5r_irq_line", {30'd0, irq_line_o}, 32'd0);
    chk("t5r_level", {28'd0, line_level_o}, 32'd0);
    chk("t5r_err", {24'd0, err_cnt_o}, 32'd0);
    reset = 1'b0;
    tick(3);
    chk("t5r_dropped_level", {28'd0, line_level_o}, 32'd0);
    chk("t5r_dropped_valid", {31'd0, irq_valid_o}, 32'd0);

    // swizzle by device number
    send(8'h20, 5'd3);
    tick(2);
    chk("t6_valid", {31'd0, irq_valid_o}, 32'd1);
    chk("t6_line", {30'd0, irq_line_o}, {30'd0, SWZ_LINE});
    chk("t6_level", {28'd0, line_level_o}, {28'd0, swz_level});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
